// File: rtl/tk1_spi_xfer_pkg.sv
// Shared definitions for the tk1 SPI master: FSM encoding, byte width, default divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tk1_spi_xfer_pkg;

    // Transfer FSM. IDLE is the only state in which new work is accepted.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } spi_state_e;

    // Bits per transfer.
    localparam int unsigned SPI_BITS = 8;

    // Default clk cycles per SCK half-period.
    localparam int unsigned SPI_CLK_DIV_DEFAULT = 2;

    // Terminal count of the half-period divider for a given CLK_DIV.
    function automatic logic [7:0] div_last(input int unsigned div);
        return 8'(div - 1);
    endfunction

endpackage

// File: rtl/tk1_spi_xfer.sv
// Byte-oriented SPI master (mode 0, MSB first) with firmware-controlled chip select.
// Latency: accepted start -> spi_ready high again in 16*CLK_DIV+2 cycles, spi_rx_data valid with it.
// Backpressure: start/tx_data are accepted only while spi_ready=1; strobes while busy are dropped.
module tk1_spi_xfer
    import tk1_spi_xfer_pkg::*;
#(
    parameter int unsigned CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       spi_ss,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    input  logic       spi_enable,
    input  logic       spi_enable_vld,
    input  logic       spi_start,
    input  logic [7:0] spi_tx_data,
    input  logic       spi_tx_data_vld,
    output logic [7:0] spi_rx_data,
    output logic       spi_ready
);

    localparam int unsigned BIT_W = $clog2(SPI_BITS);
    localparam logic [7:0] DIV_LAST = div_last(CLK_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SPI_BITS - 1);

    spi_state_e        state_q;
    logic [7:0]        div_ctr_q;
    logic [BIT_W-1:0]  bit_ctr_q;
    logic [7:0]        tx_reg_q;
    logic [7:0]        rx_shift_q;
    logic [7:0]        rx_data_q;
    logic              ss_q;
    logic              sck_q;
    logic              mosi_q;
    logic              ready_q;

    // End of the current SCK half-period.
    logic div_wrap;
    assign div_wrap = (div_ctr_q == DIV_LAST);

    // FSM, divider, bit counter, shift registers and all output registers in one update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            div_ctr_q  <= '0;
            bit_ctr_q  <= '0;
            tx_reg_q   <= 8'h00;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            ss_q       <= 1'b1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            // Chip select follows firmware in any state; it never aborts a byte in flight.
            if (spi_enable_vld) begin
                ss_q <= ~spi_enable;
            end

            case (state_q)
                ST_IDLE: begin
                    // Data load and start may coincide: the freshly loaded byte is the one sent.
                    if (spi_tx_data_vld) begin
                        tx_reg_q <= spi_tx_data;
                        mosi_q   <= spi_tx_data[7];
                    end
                    if (spi_start) begin
                        state_q   <= ST_LOW;
                        ready_q   <= 1'b0;
                        div_ctr_q <= '0;
                        bit_ctr_q <= '0;
                        sck_q     <= 1'b0;
                    end
                end

                ST_LOW: begin
                    // Rising SCK: sample MISO directly; the slave launched it on the previous fall.
                    if (div_wrap) begin
                        div_ctr_q  <= '0;
                        sck_q      <= 1'b1;
                        rx_shift_q <= {rx_shift_q[6:0], spi_miso};
                        state_q    <= ST_HIGH;
                    end else begin
                        div_ctr_q <= div_ctr_q + 8'd1;
                    end
                end

                ST_HIGH: begin
                    // Falling SCK: either finish the byte or present the next MOSI bit.
                    if (div_wrap) begin
                        div_ctr_q <= '0;
                        sck_q     <= 1'b0;
                        if (bit_ctr_q == BIT_LAST) begin
                            state_q <= ST_DONE;
                        end else begin
                            tx_reg_q  <= {tx_reg_q[6:0], 1'b0};
                            mosi_q    <= tx_reg_q[6];
                            bit_ctr_q <= bit_ctr_q + 1'b1;
                            state_q   <= ST_LOW;
                        end
                    end else begin
                        div_ctr_q <= div_ctr_q + 8'd1;
                    end
                end

                ST_DONE: begin
                    // Publish the byte and reopen for work in the same edge.
                    rx_data_q <= rx_shift_q;
                    ready_q   <= 1'b1;
                    state_q   <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign spi_ss      = ss_q;
    assign spi_sck     = sck_q;
    assign spi_mosi    = mosi_q;
    assign spi_rx_data = rx_data_q;
    assign spi_ready   = ready_q;

endmodule

// File: tb/tb_tk1_spi_xfer.sv
// Bench for tk1_spi_xfer: three instances (CLK_DIV 1, 2, 4) share stimulus, each with loopback or flash MISO.
// Latency: expected bytes queued at start, checked by a monitor when spi_ready rises.
// Backpressure: stimulus waits for all instances idle before the next accepted transfer.
`timescale 1ns/1ps
module tb_tk1_spi_xfer;

    localparam int N = 3;

    function automatic int unsigned div_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    typedef struct packed {
        logic [7:0] tx;
        logic [7:0] rx;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       spi_enable;
    logic       spi_enable_vld;
    logic       spi_start;
    logic [7:0] spi_tx_data;
    logic       spi_tx_data_vld;
    logic       loop_mode;
    logic [7:0] flash_byte;

    logic       ss_w    [N];
    logic       sck_w   [N];
    logic       mosi_w  [N];
    logic       miso_w  [N];
    logic       ready_w [N];
    logic [7:0] rx_w    [N];

    logic [2:0] fall_cnt  [N] = '{3'd0, 3'd0, 3'd0};
    int         rd_idx    [N] = '{0, 0, 0};
    logic       prev_sck  [N];
    logic       prev_ready[N];
    int         pulses    [N];
    int         run_len   [N];
    int         busy_cyc  [N];
    logic [7:0] cap       [N];
    int         busy_seen [N];

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < N; g++) begin : g_dut
        // Loopback, or a flash model shifting out flash_byte MSB first, advancing on each SCK fall.
        assign miso_w[g] = loop_mode ? mosi_w[g] : flash_byte[3'd7 - fall_cnt[g]];

        tk1_spi_xfer #(.CLK_DIV(div_of(g))) u_dut (
            .clk             (clk),
            .reset_n         (reset_n),
            .spi_ss          (ss_w[g]),
            .spi_sck         (sck_w[g]),
            .spi_mosi        (mosi_w[g]),
            .spi_miso        (miso_w[g]),
            .spi_enable      (spi_enable),
            .spi_enable_vld  (spi_enable_vld),
            .spi_start       (spi_start),
            .spi_tx_data     (spi_tx_data),
            .spi_tx_data_vld (spi_tx_data_vld),
            .spi_rx_data     (rx_w[g]),
            .spi_ready       (ready_w[g])
        );
    end

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut%0d(div=%0d): actual 0x%0h required 0x%0h", name, inst, div_of(inst), act, req);
        end
    endtask

    function automatic bit all_ready();
        bit r = 1'b1;
        for (int i = 0; i < N; i++) r &= (ready_w[i] === 1'b1);
        return r;
    endfunction

    // Monitor: SCK widths, MOSI capture, flash model position, and scoreboard pop on ready rise.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (!reset_n) begin
                prev_sck[i]   = 1'b0;
                prev_ready[i] = 1'b1;
                pulses[i]     = 0;
                run_len[i]    = 0;
                busy_cyc[i]   = 0;
                cap[i]        = 8'h00;
                fall_cnt[i]   = 3'd0;
            end else begin
                if (sck_w[i] && !prev_sck[i]) begin
                    if (pulses[i] > 0) check("sck_low_width", i, run_len[i], div_of(i));
                    pulses[i]++;
                    cap[i]     = {cap[i][6:0], mosi_w[i]};
                    run_len[i] = 1;
                end else if (!sck_w[i] && prev_sck[i]) begin
                    check("sck_high_width", i, run_len[i], div_of(i));
                    run_len[i]  = 1;
                    fall_cnt[i] = fall_cnt[i] + 3'd1;
                end else begin
                    run_len[i]++;
                end
                if (ready_w[i]) fall_cnt[i] = 3'd0;
                if (!ready_w[i]) busy_cyc[i]++;
                if (ready_w[i] && !prev_ready[i]) begin
                    if (rd_idx[i] < exp_q.size()) begin
                        e = exp_q[rd_idx[i]];
                        rd_idx[i]++;
                        check("rx_data", i, rx_w[i], e.rx);
                        check("mosi_bits", i, cap[i], e.tx);
                        check("sck_pulses", i, pulses[i], 8);
                        // ready low for 16*DIV+1 cycles = high again 16*DIV+2 cycles after the start strobe cycle
                        check("busy_cycles", i, busy_cyc[i], 16 * div_of(i) + 1);
                    end else begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done dut%0d: actual rx 0x%0h required no transfer", i, rx_w[i]);
                    end
                    pulses[i]   = 0;
                    busy_cyc[i] = 0;
                    cap[i]      = 8'h00;
                end
                prev_sck[i]   = sck_w[i];
                prev_ready[i] = ready_w[i];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!all_ready() && n < 500) begin
            step();
            n++;
        end
        if (!all_ready()) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s: actual busy after %0d cycles required ready", name, n);
        end
        // let the monitor see the ready rise before new stimulus
        step();
    endtask

    task automatic set_enable(input logic en);
        spi_enable     = en;
        spi_enable_vld = 1'b1;
        step();
        spi_enable_vld = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, input logic [7:0] rx_exp, input bit same_cycle, input bit expect_done);
        spi_tx_data     = tx;
        spi_tx_data_vld = 1'b1;
        spi_start       = same_cycle;
        step();
        spi_tx_data_vld = 1'b0;
        if (!same_cycle) begin
            spi_start = 1'b1;
            step();
        end
        spi_start = 1'b0;
        if (expect_done) exp_q.push_back({tx, rx_exp});
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        reset_n         = 1'b0;
        spi_enable      = 1'b0;
        spi_enable_vld  = 1'b0;
        spi_start       = 1'b0;
        spi_tx_data     = 8'h00;
        spi_tx_data_vld = 1'b0;
        loop_mode       = 1'b1;
        flash_byte      = 8'h3C;

        // Reset held two cycles
        step();
        step();
        for (int i = 0; i < N; i++) begin
            check("reset_ss", i, ss_w[i], 1);
            check("reset_sck", i, sck_w[i], 0);
            check("reset_ready", i, ready_w[i], 1);
            check("reset_rx", i, rx_w[i], 8'h00);
            check("reset_mosi", i, mosi_w[i], 0);
        end
        reset_n = 1'b1;
        step();

        // Loopback 0xA5 with chip select asserted
        set_enable(1'b1);
        for (int i = 0; i < N; i++) check("ss_selected", i, ss_w[i], 0);
        xfer(8'hA5, 8'hA5, 1'b0, 1'b1);
        wait_idle("loopback_a5");

        // Flash returns 0x3C; busy-time tx_data and start are dropped
        loop_mode = 1'b0;
        xfer(8'h12, 8'h3C, 1'b0, 1'b1);
        step();
        step();
        spi_tx_data     = 8'hFF;
        spi_tx_data_vld = 1'b1;
        spi_start       = 1'b1;
        step();
        spi_tx_data_vld = 1'b0;
        spi_start       = 1'b0;
        wait_idle("flash_3c");
        for (int i = 0; i < N; i++) busy_seen[i] = 0;
        for (int c = 0; c < 24; c++) begin
            for (int i = 0; i < N; i++) if (ready_w[i] !== 1'b1) busy_seen[i]++;
            step();
        end
        for (int i = 0; i < N; i++) check("busy_start_ignored", i, busy_seen[i], 0);

        // Same-cycle load and start
        loop_mode = 1'b1;
        xfer(8'h9F, 8'h9F, 1'b1, 1'b1);
        wait_idle("same_cycle_9f");

        // Chip select released mid-byte; the byte still completes
        xfer(8'h66, 8'h66, 1'b0, 1'b1);
        step();
        set_enable(1'b0);
        for (int i = 0; i < N; i++) begin
            check("ss_released_mid", i, ss_w[i], 1);
            check("busy_after_ss_release", i, ready_w[i], 0);
        end
        wait_idle("ss_release_66");

        // Reset after 3 SCK pulses of the div=2 instance; no completion expected
        xfer(8'hC3, 8'hC3, 1'b0, 1'b0);
        begin
            int n = 0;
            while (pulses[1] < 3 && n < 200) begin
                step();
                n++;
            end
            check("pulses_before_reset", 1, pulses[1], 3);
        end
        reset_n = 1'b0;
        step();
        for (int i = 0; i < N; i++) begin
            check("midreset_sck", i, sck_w[i], 0);
            check("midreset_ss", i, ss_w[i], 1);
            check("midreset_ready", i, ready_w[i], 1);
            check("midreset_rx", i, rx_w[i], 8'h00);
        end
        reset_n = 1'b1;
        step();

        // Transfer after the aborted one
        set_enable(1'b1);
        xfer(8'h3A, 8'h3A, 1'b0, 1'b1);
        wait_idle("after_reset_3a");

        for (int i = 0; i < N; i++) check("all_transfers_seen", i, rd_idx[i], exp_q.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
